// File: rtl/imm_ext_pipe_pkg.sv
// ============================================================================
//  Module      : imm_ext_pipe_pkg
//  Description : Shared constants, field-select encodings and buffer state
//                type for the immediate extender pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package imm_ext_pipe_pkg;

    localparam int c_def_out_w = 16;
    localparam int c_def_in_w  = 12;

    localparam logic [1:0] SEL_W0 = 2'd0;
    localparam logic [1:0] SEL_W1 = 2'd1;
    localparam logic [1:0] SEL_W2 = 2'd2;
    localparam logic [1:0] SEL_W3 = 2'd3;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/imm_ext_core.sv
// ============================================================================
//  Module      : imm_ext_core
//  Description : Combinational sign/zero extender with four selectable
//                source-field widths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int OUT_W = c_def_out_w,
    parameter int IN_W  = c_def_in_w,
    parameter int W0    = 4,
    parameter int W1    = 8,
    parameter int W2    = 9,
    parameter int W3    = 12
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       sel,
    input  logic             sgn,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] w_ext [4];

    for (genvar n = 0; n < 4; n++) begin : g_field
        localparam int c_w = (n == 0) ? W0 : (n == 1) ? W1 : (n == 2) ? W2 : W3;

        // A field as wide as the datapath needs no padding bits at all.
        if (c_w < OUT_W) begin : g_pad
            logic w_fill;
            assign w_fill   = sgn & imm[c_w-1];
            assign w_ext[n] = {{(OUT_W - c_w){w_fill}}, imm[c_w-1:0]};
        end else begin : g_full
            assign w_ext[n] = imm[OUT_W-1:0];
        end
    end

    always_comb begin
        ext = w_ext[0];
        case (sel)
            SEL_W0:  ext = w_ext[0];
            SEL_W1:  ext = w_ext[1];
            SEL_W2:  ext = w_ext[2];
            SEL_W3:  ext = w_ext[3];
            default: ext = w_ext[0];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
//  Module      : imm_ext_pipe
//  Description : Pipelined immediate extender with a registered 2-entry
//                skid buffer on the valid/ready output.
//                Optional feature macro: IMM_EXT_SHIFT_EN (adds in_shl).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int OUT_W = c_def_out_w,
    parameter int IN_W  = c_def_in_w,
    parameter int W0    = 4,
    parameter int W1    = 8,
    parameter int W2    = 9,
    parameter int W3    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_sel,
    input  logic             in_sgn,
`ifdef IMM_EXT_SHIFT_EN
    input  logic             in_shl,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       occ
);

    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] w_store;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head;
    logic             w_load_tail;
    logic             w_head_from_tail;
    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_tail;

    imm_ext_core #(
        .OUT_W (OUT_W),
        .IN_W  (IN_W),
        .W0    (W0),
        .W1    (W1),
        .W2    (W2),
        .W3    (W3)
    ) u_core (
        .imm (in_imm),
        .sel (in_sel),
        .sgn (in_sgn),
        .ext (w_ext)
    );

`ifdef IMM_EXT_SHIFT_EN
    // Halfword branch offsets: scale by two before storing.
    assign w_store = in_shl ? {w_ext[OUT_W-2:0], 1'b0} : w_ext;
`else
    assign w_store = w_ext;
`endif

    assign in_ready  = !rst && (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_head;
    assign occ       = r_state;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_load_tail      = 1'b0;
        w_head_from_tail = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ONE;
                        w_load_head = 1'b1;
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            w_state_nxt = FULL;
                            w_load_tail = 1'b1;
                        end
                        2'b01:   w_state_nxt = EMPTY;
                        2'b11:   w_load_head = 1'b1;
                        default: w_state_nxt = ONE;
                    endcase
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ONE;
                        w_head_from_tail = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_head) begin
                r_head <= w_store;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_store;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
// ============================================================================
//  Module      : tb_imm_ext_pipe
//  Description : Self-checking bench for imm_ext_pipe with a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_imm;
    logic [1:0]  in_sel;
    logic        in_sgn;
    logic        in_shl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occ;

    int errs   = 0;
    int checks = 0;
    logic [15:0] q[$];

    imm_ext_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_sel    (in_sel),
        .in_sgn    (in_sgn),
`ifdef IMM_EXT_SHIFT_EN
        .in_shl    (in_shl),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [11:0] imm, input logic [1:0] sel,
                                          input logic sgn, input logic shl);
        int          w;
        logic [15:0] m;
        logic [15:0] v;
        case (sel)
            2'd0:    w = 4;
            2'd1:    w = 8;
            2'd2:    w = 9;
            default: w = 12;
        endcase
        m = 16'((32'd1 << w) - 32'd1);
        v = {4'd0, imm} & m;
        if (sgn && imm[w-1]) v = v | ~m;
        if (shl) v = {v[14:0], 1'b0};
        return v;
    endfunction

    // Scoreboard: sampled mid-cycle, ahead of the edge that commits handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            check("sb_occ", 32'(occ), 32'(q.size()));
            check("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("sb_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    check("sb_data", 32'(out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) begin
`ifdef IMM_EXT_SHIFT_EN
                    q.push_back(model(in_imm, in_sel, in_sgn, in_shl));
`else
                    q.push_back(model(in_imm, in_sel, in_sgn, 1'b0));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] imm, input logic [1:0] sel,
                         input logic sgn);
        in_valid = v;
        in_imm   = imm;
        in_sel   = sel;
        in_sgn   = sgn;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_shl = 1'b0;
        drive(1'b0, 12'h000, 2'd0, 1'b0);
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Extension patterns with the consumer always ready.
        out_ready = 1'b1;
        drive(1'b1, 12'h008, 2'd0, 1'b1); tick();
        check("w0_sgn", 32'(out_data), 32'h0000_FFF8);
        check("w0_sgn_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 12'h008, 2'd0, 1'b0); tick();
        check("w0_zero", 32'(out_data), 32'h0000_0008);
        drive(1'b1, 12'h100, 2'd2, 1'b1); tick();
        check("w2_sgn", 32'(out_data), 32'h0000_FF00);
        drive(1'b1, 12'h100, 2'd2, 1'b0); tick();
        check("w2_zero", 32'(out_data), 32'h0000_0100);
        drive(1'b1, 12'h7FF, 2'd3, 1'b1); tick();
        check("w3_pos", 32'(out_data), 32'h0000_07FF);
        check("stream_occ", 32'(occ), 32'd1);
        drive(1'b0, 12'h000, 2'd0, 1'b0); tick();
        check("drain_occ", 32'(occ), 32'd0);

        // Backpressure: A and B fill the buffer, C waits.
        out_ready = 1'b0;
        drive(1'b1, 12'h001, 2'd3, 1'b0); tick();
        check("bp_occ1", 32'(occ), 32'd1);
        drive(1'b1, 12'h002, 2'd3, 1'b0); tick();
        check("bp_occ2", 32'(occ), 32'd2);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        drive(1'b1, 12'h003, 2'd3, 1'b0); tick();
        check("bp_hold_occ", 32'(occ), 32'd2);
        check("bp_hold_data", 32'(out_data), 32'h0000_0001);
        out_ready = 1'b1; tick();
        check("bp_pop_b", 32'(out_data), 32'h0000_0002);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("pushpop_occ", 32'(occ), 32'd1);
        check("pushpop_c", 32'(out_data), 32'h0000_0003);
        drive(1'b0, 12'h000, 2'd0, 1'b0); tick();
        check("bp_empty", 32'(occ), 32'd0);

        // Flush while FULL with a push attempt, then flush in ONE with a push.
        out_ready = 1'b0;
        drive(1'b1, 12'h0AA, 2'd3, 1'b0); tick();
        drive(1'b1, 12'h0BB, 2'd3, 1'b0); tick();
        drive(1'b1, 12'h0CC, 2'd3, 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        check("flush_full_occ", 32'(occ), 32'd0);
        check("flush_full_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 12'h011, 2'd3, 1'b0); tick();
        drive(1'b1, 12'h022, 2'd3, 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        drive(1'b0, 12'h000, 2'd0, 1'b0);
        check("flush_one_occ", 32'(occ), 32'd0);
        out_ready = 1'b1; tick(); tick();
        check("flush_no_ghost", 32'(out_valid), 32'd0);

`ifdef IMM_EXT_SHIFT_EN
        in_shl = 1'b1;
        drive(1'b1, 12'h080, 2'd1, 1'b1); tick();
        check("shl_w1", 32'(out_data), 32'h0000_FF00);
        in_shl = 1'b0;
        drive(1'b0, 12'h000, 2'd0, 1'b0); tick();
`endif

        // Reset while FULL.
        out_ready = 1'b0;
        drive(1'b1, 12'h0F0, 2'd3, 1'b1); tick();
        drive(1'b1, 12'h0F1, 2'd3, 1'b1); tick();
        drive(1'b0, 12'h000, 2'd0, 1'b0);
        rst = 1'b1; tick();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_occ", 32'(occ), 32'd0);
        rst = 1'b0; tick();

        // Random traffic checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 12'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
`ifdef IMM_EXT_SHIFT_EN
            in_shl = 1'($urandom_range(0, 1));
`endif
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 12'h000, 2'd0, 1'b0);
        tick(); tick(); tick();
        check("final_drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
